// File: rtl/data_sampler_fifo.sv
// rtl/data_sampler_fifo.sv - trigger-armed wide-word snapshot sampler feeding a FWFT output FIFO
// A TRIG rise arms one capture; the captured word is sliced LSB-first into the FIFO.
module data_sampler_fifo #(
  parameter int DIN_WIDTH  = 512,
  parameter int DOUT_WIDTH = 32,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  TRIG,
  input  logic [DIN_WIDTH-1:0]  DIN,
  input  logic                  DIN_VALID,
  output logic [DOUT_WIDTH-1:0] DOUT,
  output logic                  DOUT_EMPTY,
  input  logic                  DOUT_RDEN
);

  localparam int RATIO = DIN_WIDTH / DOUT_WIDTH;
  localparam int CNT_W = $clog2(RATIO + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(RATIO - 1);
  localparam logic [AW:0]      DEPTH_L    = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

  state_t                state_q, state_d;
  logic                  trig_q, trig_d;
  logic [DIN_WIDTH-1:0]  capture_q, capture_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [DOUT_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic rise, full, empty, wr_en, rd_en;

  always_comb begin
    rise  = TRIG & ~trig_q;
    full  = (count_q == DEPTH_L);
    empty = (count_q == '0);
    wr_en = (state_q == SHIFT) & ~full;
    rd_en = DOUT_RDEN & ~empty;
  end

  // Rises seen outside IDLE are dropped, not queued.
  always_comb begin
    state_d   = state_q;
    trig_d    = TRIG;
    capture_d = capture_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: if (rise) state_d = ARMED;
      ARMED: begin
        if (DIN_VALID) begin
          capture_d = DIN;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (wr_en) begin
          capture_d = capture_q >> DOUT_WIDTH;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == LAST_SLICE) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      trig_q    <= 1'b0;
      capture_q <= '0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      trig_q    <= trig_d;
      capture_q <= capture_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage is cleared on reset so the head word reads 0 out of reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= capture_q[DOUT_WIDTH-1:0];
    end
  end

  assign DOUT       = mem_q[rd_ptr_q];
  assign DOUT_EMPTY = empty;

endmodule

// File: tb/tb_data_sampler_fifo.sv
// tb/tb_data_sampler_fifo.sv - directed table and sequence checks for data_sampler_fifo
// Runs with a 16-deep FIFO so the full-stall behaviour is reachable.
module tb_data_sampler_fifo;

  localparam int DW = 512;
  localparam int OW = 32;
  localparam int NS = DW / OW;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          TRIG = 1'b0;
  logic [DW-1:0] DIN = '0;
  logic          DIN_VALID = 1'b0;
  logic [OW-1:0] DOUT;
  logic          DOUT_EMPTY;
  logic          DOUT_RDEN = 1'b0;

  int checks = 0;
  int failures = 0;

  data_sampler_fifo #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW), .FIFO_DEPTH(16)) dut (
    .CLK(CLK), .RESET(RESET), .TRIG(TRIG), .DIN(DIN), .DIN_VALID(DIN_VALID),
    .DOUT(DOUT), .DOUT_EMPTY(DOUT_EMPTY), .DOUT_RDEN(DOUT_RDEN)
  );

  initial forever #10 CLK = ~CLK;

  typedef struct {
    logic        trig;
    logic        dv;
    logic        rd;
    logic        exp_empty;
    logic        chk_dout;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs [21];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [31:0] base);
    logic [DW-1:0] w;
    for (int i = 0; i < NS; i++) w[i*OW +: OW] = base + 32'(i);
    return w;
  endfunction

  task automatic read_word(input logic [31:0] exp, input string name);
    int n = 0;
    while (DOUT_EMPTY && n < 50) begin
      tick();
      n++;
    end
    chk({name, "_avail"}, 32'(DOUT_EMPTY), 32'd0);
    chk(name, DOUT, exp);
    DOUT_RDEN = 1'b1;
    tick();
    DOUT_RDEN = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 21; i++) begin
      vecs[i].trig      = (i == 0);
      vecs[i].dv        = 1'b1;
      vecs[i].rd        = 1'b1;
      vecs[i].exp_empty = (i < 2 || i > 17);
      vecs[i].chk_dout  = (i >= 2 && i <= 17);
      vecs[i].exp_dout  = 32'(i - 2);
    end

    // Reset held with TRIG toggling.
    #5 RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      TRIG = ~TRIG;
      tick();
      chk($sformatf("rst_empty%0d", i), 32'(DOUT_EMPTY), 32'd1);
      chk($sformatf("rst_dout%0d", i), DOUT, 32'd0);
    end
    TRIG = 1'b0;
    RESET = 1'b1;
    DIN_VALID = 1'b1;
    DIN = mk(32'h0);
    repeat (4) tick();
    chk("post_rst_no_write", 32'(DOUT_EMPTY), 32'd1);

    // Basic capture with continuous reads.
    for (int i = 0; i < 21; i++) begin
      TRIG = vecs[i].trig;
      DIN_VALID = vecs[i].dv;
      DOUT_RDEN = vecs[i].rd;
      tick();
      chk($sformatf("basic_empty%0d", i), 32'(DOUT_EMPTY), 32'(vecs[i].exp_empty));
      if (vecs[i].chk_dout) chk($sformatf("basic_dout%0d", i), DOUT, vecs[i].exp_dout);
    end
    DOUT_RDEN = 1'b0;

    // Armed wait for DIN_VALID.
    DIN_VALID = 1'b0;
    DIN = mk(32'hFFFF_0000);
    TRIG = 1'b1;
    tick();
    TRIG = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("armed_empty%0d", i), 32'(DOUT_EMPTY), 32'd1);
    end
    DIN = mk(32'hA5A5_0000);
    DIN_VALID = 1'b1;
    tick();
    DIN_VALID = 1'b0;
    DIN = mk(32'h1234_0000);
    for (int i = 0; i < NS; i++) read_word(32'hA5A5_0000 + 32'(i), $sformatf("A%0d", i));
    repeat (3) tick();
    chk("armed_done_empty", 32'(DOUT_EMPTY), 32'd1);

    // Held TRIG, retrigger during SHIFT, then a second capture into a full FIFO.
    DIN = mk(32'hB000_0100);
    DIN_VALID = 1'b1;
    TRIG = 1'b1;
    repeat (5) tick();
    TRIG = 1'b0;
    repeat (3) tick();
    TRIG = 1'b1;
    tick();
    TRIG = 1'b0;
    repeat (20) tick();
    chk("full_b_not_empty", 32'(DOUT_EMPTY), 32'd0);
    DIN = mk(32'hC0DE_0000);
    TRIG = 1'b1;
    tick();
    TRIG = 1'b0;
    tick();
    DIN = mk(32'hDEAD_0000);
    TRIG = 1'b1;
    tick();
    TRIG = 1'b0;
    repeat (5) tick();
    for (int i = 0; i < NS; i++) read_word(32'hB000_0100 + 32'(i), $sformatf("B%0d", i));
    for (int i = 0; i < NS; i++) read_word(32'hC0DE_0000 + 32'(i), $sformatf("C%0d", i));
    repeat (5) tick();
    chk("stall_no_extra", 32'(DOUT_EMPTY), 32'd1);

    // Underflow attempt.
    DOUT_RDEN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("underflow_empty%0d", i), 32'(DOUT_EMPTY), 32'd1);
    end
    DOUT_RDEN = 1'b0;

    // Reset in the middle of SHIFT.
    DIN = mk(32'hD000_0000);
    TRIG = 1'b1;
    tick();
    TRIG = 1'b0;
    repeat (4) tick();
    chk("mid_shift_not_empty", 32'(DOUT_EMPTY), 32'd0);
    RESET = 1'b0;
    #2;
    chk("mid_rst_empty", 32'(DOUT_EMPTY), 32'd1);
    chk("mid_rst_dout", DOUT, 32'd0);
    tick();
    tick();
    RESET = 1'b1;
    repeat (20) tick();
    chk("after_rst_idle", 32'(DOUT_EMPTY), 32'd1);
    DIN = mk(32'hE000_0010);
    TRIG = 1'b1;
    tick();
    TRIG = 1'b0;
    for (int i = 0; i < NS; i++) read_word(32'hE000_0010 + 32'(i), $sformatf("E%0d", i));
    tick();
    chk("final_empty", 32'(DOUT_EMPTY), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
